// File: rtl/operand_fetch_pkg.sv
// Shared widths, opcode/funct constants and decode types for the operand-fetch stage.
package operand_fetch_pkg;
  localparam int RegAddrBus = 5;
  localparam int DataBus = 32;
  localparam logic RstEnable = 1'b1;

  typedef logic [RegAddrBus-1:0] reg_addr_t;
  typedef logic [DataBus-1:0] data_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_HIGH} imm_kind_e;

  typedef struct packed {
    logic use_rs;
    logic use_rt;
    logic we;
    reg_addr_t waddr;
    data_t imm;
  } decode_t;

  function automatic data_t extend_imm(input logic [15:0] imm16, input imm_kind_e kind);
    case (kind)
      IMM_ZERO: return {16'h0, imm16};
      IMM_HIGH: return {imm16, 16'h0};
      default:  return {{16{imm16[15]}}, imm16};
    endcase
  endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// Instruction channel into operand fetch and decoded-operand channel out of it.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  // Both channels: a beat transfers on a rising edge where valid and ready are
  // both high; the sender holds valid and payload until then, and ready may
  // depend combinationally on valid.
  logic in_valid;
  logic in_ready;
  data_t in_inst;
  data_t in_pc;
  logic out_valid;
  logic out_ready;
  data_t out_pc;
  data_t out_opa;
  data_t out_opb;
  data_t out_imm;
  logic [5:0] out_op;
  logic [5:0] out_funct;
  reg_addr_t out_waddr;
  logic out_we;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input in_ready, out_valid, out_pc, out_opa, out_opb, out_imm,
    input out_op, out_funct, out_waddr, out_we
  );

  modport slave (
    input in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opa, out_opb, out_imm,
    output out_op, out_funct, out_waddr, out_we
  );
endinterface

// File: rtl/operand_fetch_op_decode.sv
// Combinational instruction decode: which sources are read, destination,
// write enable and extended immediate.
module op_decode
  import operand_fetch_pkg::*;
(
  input data_t inst,
  output decode_t dec
);
  logic [5:0] op;
  logic [5:0] funct;
  imm_kind_e kind;
  logic unused_shamt;

  assign op = inst[31:26];
  assign funct = inst[5:0];
  assign unused_shamt = ^inst[10:6];

  always_comb begin
    dec.use_rs = 1'b0;
    dec.use_rt = 1'b0;
    dec.we = 1'b0;
    dec.waddr = '0;
    kind = IMM_SIGN;
    case (op)
      OP_SPECIAL: begin
        dec.use_rs = 1'b1;
        dec.use_rt = 1'b1;
        dec.waddr = inst[15:11];
        dec.we = (funct != FUNCT_JR);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        dec.use_rs = 1'b1;
        dec.waddr = inst[20:16];
        dec.we = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.use_rs = 1'b1;
        dec.waddr = inst[20:16];
        dec.we = 1'b1;
        kind = IMM_ZERO;
      end
      OP_LUI: begin
        dec.waddr = inst[20:16];
        dec.we = 1'b1;
        kind = IMM_HIGH;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        dec.use_rs = 1'b1;
        dec.use_rt = 1'b1;
      end
      default: ;
    endcase
    dec.imm = extend_imm(inst[15:0], kind);
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register reads, ex/mem forwarding, load-use stall and
// the output pipeline register towards execute.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input logic clk,
  input logic rst,
  operand_fetch_if.slave bus,
  output logic re0,
  output reg_addr_t raddr0,
  input data_t rdata0,
  output logic re1,
  output reg_addr_t raddr1,
  input data_t rdata1,
  input logic ex_we,
  input logic ex_is_load,
  input reg_addr_t ex_waddr,
  input data_t ex_wdata,
  input logic mem_we,
  input reg_addr_t mem_waddr,
  input data_t mem_wdata,
  input logic flush
);
  decode_t dec;
  reg_addr_t rs;
  reg_addr_t rt;
  data_t opa;
  data_t opb;
  logic ex_fwd;
  logic load_pending;
  logic hazard;
  logic advance;
  logic take;

  op_decode u_decode (
    .inst(bus.in_inst),
    .dec(dec)
  );

  assign rs = bus.in_inst[25:21];
  assign rt = bus.in_inst[20:16];
  assign raddr0 = rs;
  assign raddr1 = rt;
  assign re0 = bus.in_valid & dec.use_rs;
  assign re1 = bus.in_valid & dec.use_rt;

  // A load in execute has no data yet, so it is never a forwarding source.
  function automatic data_t select_operand(
    input reg_addr_t addr, input logic used, input data_t rf, input logic exf,
    input reg_addr_t exa, input data_t exd, input logic mwe, input reg_addr_t ma,
    input data_t md
  );
    if (!used || addr == '0) return '0;
    if (exf && exa == addr) return exd;
    if (mwe && ma == addr) return md;
    return rf;
  endfunction

  assign ex_fwd = ex_we & ~ex_is_load;
  assign opa = select_operand(rs, dec.use_rs, rdata0, ex_fwd, ex_waddr, ex_wdata,
                              mem_we, mem_waddr, mem_wdata);
  assign opb = select_operand(rt, dec.use_rt, rdata1, ex_fwd, ex_waddr, ex_wdata,
                              mem_we, mem_waddr, mem_wdata);

  assign load_pending = ex_we & ex_is_load & (ex_waddr != '0);
  assign hazard = bus.in_valid & load_pending &
                  ((dec.use_rs & (ex_waddr == rs)) | (dec.use_rt & (ex_waddr == rt)));
  assign advance = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance & ~hazard & ~flush & (rst != RstEnable);
  assign take = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      bus.out_valid <= 1'b0;
      bus.out_we <= 1'b0;
      bus.out_op <= '0;
      bus.out_funct <= '0;
      bus.out_waddr <= '0;
      bus.out_pc <= '0;
      bus.out_opa <= '0;
      bus.out_opb <= '0;
      bus.out_imm <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (advance) begin
      // Without a transfer this inserts a bubble; payload fields just hold.
      bus.out_valid <= take;
      if (take) begin
        bus.out_pc <= bus.in_pc;
        bus.out_opa <= opa;
        bus.out_opb <= opb;
        bus.out_imm <= dec.imm;
        bus.out_op <= bus.in_inst[31:26];
        bus.out_funct <= bus.in_inst[5:0];
        bus.out_waddr <= dec.waddr;
        bus.out_we <= dec.we;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a randomized
// run scored against a behavioural model of decode, forwarding and stalls.
module tb_operand_fetch;
  localparam int W = 146;

  logic clk = 1'b0;
  logic rst;
  logic re0, re1;
  logic [4:0] raddr0, raddr1;
  logic [31:0] rdata0, rdata1;
  logic ex_we, ex_is_load, mem_we, flush;
  logic [4:0] ex_waddr, mem_waddr;
  logic [31:0] ex_wdata, mem_wdata;
  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch_if bus ();

  assign rdata0 = regs[raddr0];
  assign rdata1 = regs[raddr1];

  operand_fetch dut (
    .clk(clk), .rst(rst), .bus(bus),
    .re0(re0), .raddr0(raddr0), .rdata0(rdata0),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .flush(flush)
  );

  // Output bundle: pc[145:114] opa[113:82] opb[81:50] imm[49:18] op[17:12] funct[11:6] waddr[5:1] we[0]
  wire [W-1:0] act = {bus.out_pc, bus.out_opa, bus.out_opb, bus.out_imm,
                      bus.out_op, bus.out_funct, bus.out_waddr, bus.out_we};

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] fwd_value(input logic [4:0] r, input logic used);
    if (!used || r == 5'd0) return 32'h0;
    if (ex_we && !ex_is_load && ex_waddr == r) return ex_wdata;
    if (mem_we && mem_waddr == r) return mem_wdata;
    return regs[r];
  endfunction

  // Reference: expected output bundle, compare mask and source usage.
  function automatic void model(input logic [31:0] inst, input logic [31:0] pc,
                                output logic [W-1:0] e, output logic [W-1:0] m,
                                output logic urs, output logic urt);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, wa;
    logic [15:0] i16;
    logic [31:0] imm, a, b;
    logic we, imm_ok, wa_ok;
    op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11];
    i16 = inst[15:0]; fn = inst[5:0];
    urs = 1'b0; urt = 1'b0; we = 1'b0; wa = 5'd0; imm = 32'h0; imm_ok = 1'b0; wa_ok = 1'b1;
    if (op == 6'h00) begin
      urs = 1'b1; urt = 1'b1; wa = rd; we = (fn != 6'h08);
    end else if (op >= 6'h08 && op <= 6'h0B) begin
      urs = 1'b1; wa = rt; we = 1'b1; imm = {{16{i16[15]}}, i16}; imm_ok = 1'b1;
    end else if (op >= 6'h0C && op <= 6'h0E) begin
      urs = 1'b1; wa = rt; we = 1'b1; imm = {16'h0, i16}; imm_ok = 1'b1;
    end else if (op == 6'h0F) begin
      wa = rt; we = 1'b1; imm = {i16, 16'h0}; imm_ok = 1'b1;
    end else if (op == 6'h23) begin
      urs = 1'b1; wa = rt; we = 1'b1;
    end else if (op == 6'h2B || op == 6'h04 || op == 6'h05) begin
      urs = 1'b1; urt = 1'b1; wa_ok = 1'b0;
    end
    a = fwd_value(rs, urs);
    b = fwd_value(rt, urt);
    e = {pc, a, b, imm, op, fn, wa, we};
    m = '1;
    if (!imm_ok) m[49:18] = '0;
    if (!wa_ok) m[5:1] = '0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0] op, fn;
    logic [15:0] low;
    case ($urandom_range(0, 14))
      0, 1: op = 6'h00;
      2: op = 6'h08; 3: op = 6'h09; 4: op = 6'h0A; 5: op = 6'h0B;
      6: op = 6'h0C; 7: op = 6'h0D; 8: op = 6'h0E; 9: op = 6'h0F;
      10: op = 6'h23; 11: op = 6'h2B; 12: op = 6'h04; 13: op = 6'h05;
      default: op = 6'h02;
    endcase
    case ($urandom_range(0, 3))
      0: fn = 6'h21; 1: fn = 6'h23; 2: fn = 6'h08; default: fn = 6'h25;
    endcase
    low = 16'($urandom);
    if (op == 6'h00) low = {5'($urandom_range(0, 7)), 5'h00, fn};
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), low};
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_inst = 32'h0; bus.in_pc = 32'h0; bus.out_ready = 1'b1;
    ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'h0;
    mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'h0; flush = 1'b0;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1; bus.in_inst = inst; bus.in_pc = pc;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(r_type(5'd1, 5'd2, 5'd3, 6'h21), 32'h40);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (act !== '0) begin errors++; $display("FAIL reset_fields: got %h want 0", act); end
    rst = 1'b0; idle();
  endtask

  task automatic test_addu();
    regs[1] = 32'd5; regs[2] = 32'd7;
    drive(r_type(5'd1, 5'd2, 5'd3, 6'h21), 32'h100);
    #1;
    checks++; if ({bus.in_ready, re0, re1} !== 3'b111) begin errors++; $display("FAIL addu_ready_re: got %b want 111", {bus.in_ready, re0, re1}); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addu_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_opa !== 32'd5 || bus.out_opb !== 32'd7) begin errors++; $display("FAIL addu_ops: got %h %h want 5 7", bus.out_opa, bus.out_opb); end
    checks++; if (bus.out_waddr !== 5'd3 || bus.out_we !== 1'b1) begin errors++; $display("FAIL addu_dest: got %0d %b want 3 1", bus.out_waddr, bus.out_we); end
    idle();
  endtask

  task automatic test_forward();
    ex_we = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h10;
    mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'h20;
    drive(i_type(6'h09, 5'd3, 5'd4, 16'hFFFF), 32'h104);
    @(negedge clk);
    checks++; if (bus.out_opa !== 32'h10) begin errors++; $display("FAIL fwd_ex_opa: got %h want 00000010", bus.out_opa); end
    checks++; if (bus.out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL fwd_imm: got %h want ffffffff", bus.out_imm); end
    checks++; if (bus.out_waddr !== 5'd4 || bus.out_opb !== 32'h0) begin errors++; $display("FAIL fwd_dest_opb: got %0d %h want 4 0", bus.out_waddr, bus.out_opb); end
    idle();
  endtask

  task automatic test_load_use();
    regs[1] = 32'd5;
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'h77;
    drive(r_type(5'd2, 5'd1, 5'd5, 6'h21), 32'h108);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b want 0", bus.out_valid); end
    ex_we = 1'b0; ex_is_load = 1'b0;
    mem_we = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'd9;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lu_release_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_opa !== 32'd9 || bus.out_opb !== 32'd5) begin
      errors++; $display("FAIL lu_accept: got v=%b %h %h want 1 9 5", bus.out_valid, bus.out_opa, bus.out_opb); end
    idle();
  endtask

  task automatic test_stall();
    regs[1] = 32'd5; regs[2] = 32'd7;
    drive(i_type(6'h09, 5'd1, 5'd6, 16'd5), 32'h200);
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(i_type(6'h0D, 5'd2, 5'd7, 16'h1234), 32'h204);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b want 0", i, bus.in_ready); end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_opa !== 32'd5 || bus.out_imm !== 32'd5) begin
        errors++; $display("FAIL stall_hold_%0d: got v=%b pc=%h opa=%h imm=%h want 1 200 5 5", i, bus.out_valid, bus.out_pc, bus.out_opa, bus.out_imm); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_pc !== 32'h204 || bus.out_opa !== 32'd7 || bus.out_imm !== 32'h1234 || bus.out_waddr !== 5'd7) begin
      errors++; $display("FAIL stall_next: got pc=%h opa=%h imm=%h wa=%0d want 204 7 1234 7", bus.out_pc, bus.out_opa, bus.out_imm, bus.out_waddr); end
    idle();
  endtask

  task automatic test_flush();
    flush = 1'b1;
    drive(r_type(5'd1, 5'd2, 5'd3, 6'h21), 32'h300);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    flush = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stalled: got %b want 0", bus.out_valid); end
    flush = 1'b0; bus.out_ready = 1'b1;
    drive(r_type(5'd1, 5'd2, 5'd3, 6'h21), 32'h304);
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(r_type(5'd2, 5'd1, 5'd4, 6'h21), 32'h308);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || act !== '0) begin errors++; $display("FAIL rst_mid_clear: got v=%b %h want 0 0", bus.out_valid, act); end
    rst = 1'b0; idle();
  endtask

  task automatic test_zero_reg();
    regs[0] = 32'h0;
    ex_we = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hDEAD;
    mem_we = 1'b1; mem_waddr = 5'd0; mem_wdata = 32'hBEEF;
    drive(i_type(6'h0D, 5'd0, 5'd1, 16'h8000), 32'h400);
    #1;
    checks++; if ({re0, re1} !== 2'b10) begin errors++; $display("FAIL zero_re: got %b want 10", {re0, re1}); end
    @(negedge clk);
    checks++; if (bus.out_opa !== 32'h0 || bus.out_opb !== 32'h0) begin errors++; $display("FAIL zero_ops: got %h %h want 0 0", bus.out_opa, bus.out_opb); end
    checks++; if (bus.out_imm !== 32'h00008000 || bus.out_waddr !== 5'd1) begin errors++; $display("FAIL zero_imm: got %h %0d want 00008000 1", bus.out_imm, bus.out_waddr); end
    idle();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    logic [W-1:0] e, m;
    logic urs, urt, hz, exp_rdy;
    logic [31:0] pc;
    pc = 32'h1000;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    rst = 1'b1; idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 500; cyc++) begin
      checks++;
      if (bus.out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rand_valid c%0d: got %b want %b", cyc, bus.out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (((act ^ exp_q[0]) & mask_q[0]) !== '0) begin
          errors++; $display("FAIL rand_data c%0d: got %h want %h", cyc, act & mask_q[0], exp_q[0] & mask_q[0]);
        end
      end
      bus.in_valid = ($urandom_range(0, 4) != 0);
      bus.in_inst = rand_inst();
      bus.in_pc = pc;
      pc = pc + 32'd4;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      ex_we = ($urandom_range(0, 1) != 0);
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_waddr = 5'($urandom_range(0, 7));
      ex_wdata = $urandom;
      mem_we = ($urandom_range(0, 1) != 0);
      mem_waddr = 5'($urandom_range(0, 7));
      mem_wdata = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      #1;
      model(bus.in_inst, bus.in_pc, e, m, urs, urt);
      hz = bus.in_valid && ex_we && ex_is_load && ex_waddr != 5'd0 &&
           ((urs && ex_waddr == bus.in_inst[25:21]) || (urt && ex_waddr == bus.in_inst[20:16]));
      exp_rdy = (exp_q.size() == 0 || bus.out_ready) && !hz && !flush;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, bus.in_ready, exp_rdy);
      end
      checks++;
      if ({re0, re1} !== {bus.in_valid & urs, bus.in_valid & urt}) begin
        errors++; $display("FAIL rand_re c%0d: got %b want %b", cyc, {re0, re1}, {bus.in_valid & urs, bus.in_valid & urt});
      end
      if (flush) begin
        exp_q.delete(); mask_q.delete();
      end else begin
        if (exp_q.size() != 0 && bus.out_ready) begin
          void'(exp_q.pop_front()); void'(mask_q.pop_front());
        end
        if (bus.in_valid && exp_rdy) begin
          exp_q.push_back(e); mask_q.push_back(m);
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_addu();
    test_forward();
    test_load_use();
    test_stall();
    test_flush();
    test_zero_reg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
